cache_fill_fsm: RTL and testbench

- Miss handler on the memory side of the direct-mapped cache (16-byte blocks, 8 x 16-bit words, 5-bit tag, 7-bit index).
- On a miss reported by the cache, it reads the whole block from a pipelined multi-cycle memory.
- It streams each returned word into the cache data array, then validates the tag in the metadata array on the last word.
- Its busy output is the stall source for the fetch/memory pipeline stages.

---
 rtl/cache_fill_fsm.sv | 121 ++++++++++++
 tb/tb_cache_fill_fsm.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache miss block-fill controller (option: CRITICAL_WORD_FIRST_EN)
// Issues one word read per cycle for the missed block and streams returns into the data array.
module cache_fill_fsm #(
  parameter int WORDS_LOG2 = 3,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_word_addr
);

  localparam int BLK_W = ADDR_W - WORDS_LOG2 - 1;
  localparam int CNT_W = WORDS_LOG2 + 1;
  localparam logic [CNT_W-1:0] C_WORDS = CNT_W'(1 << WORDS_LOG2);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'((1 << WORDS_LOG2) - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [BLK_W-1:0]      r_blk;
  logic [CNT_W-1:0]      r_issue_cnt;
  logic [CNT_W-1:0]      r_recv_cnt;
  logic                  w_accept;
  logic                  w_read;
  logic                  w_write;
  logic                  w_last;
  logic [WORDS_LOG2-1:0] w_issue_off;
  logic [WORDS_LOG2-1:0] w_recv_off;
  logic                  w_unused_bits;

  // Data flows to the array outside this block; low address bits only matter for word order.
  assign w_unused_bits = ^{memory_data, miss_address[WORDS_LOG2:0]};

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_read       = 1'b0;
    w_write      = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (miss_detected) begin
          w_next_state = ST_FILL;
          w_accept     = 1'b1;
        end
      end
      ST_FILL: begin
        w_read  = (r_issue_cnt < C_WORDS);
        w_write = memory_data_valid;
        w_last  = memory_data_valid && (r_recv_cnt == C_LAST);
        if (w_last) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_blk       <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_blk       <= miss_address[ADDR_W-1:WORDS_LOG2+1];
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end else begin
        if (w_read) begin
          r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        end
        if (w_write) begin
          r_recv_cnt <= w_last ? '0 : r_recv_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  logic [WORDS_LOG2-1:0] r_w0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_w0 <= '0;
    end else if (w_accept) begin
      r_w0 <= miss_address[WORDS_LOG2:1];
    end
  end

  // Offsets are WORDS_LOG2 bits wide so the sum wraps around the block.
  assign w_issue_off = r_w0 + r_issue_cnt[WORDS_LOG2-1:0];
  assign w_recv_off  = r_w0 + r_recv_cnt[WORDS_LOG2-1:0];
`else
  assign w_issue_off = r_issue_cnt[WORDS_LOG2-1:0];
  assign w_recv_off  = r_recv_cnt[WORDS_LOG2-1:0];
`endif

  assign fsm_busy         = (r_state == ST_FILL);
  assign memory_read      = w_read;
  assign memory_address   = {r_blk, w_issue_off, 1'b0};
  assign write_data_array = w_write;
  assign write_tag_array  = w_last;
  assign cache_word_addr  = {r_blk, w_recv_off, 1'b0};

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm
`timescale 1ns/1ps
module tb_cache_fill_fsm;

  localparam int WL2 = 3;
  localparam int NW  = 1 << WL2;
`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic [15:0] memory_data = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy;
  logic        memory_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_word_addr;

  cache_fill_fsm #(.WORDS_LOG2(WL2), .ADDR_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read       (memory_read),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .cache_word_addr   (cache_word_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a fill is "base address + a word sequence starting at w0".
  bit m_busy = 1'b0;
  int m_base = 0;
  int m_w0 = 0;
  int m_issued = 0;
  int m_recv = 0;

  // Bench memory: fixed-latency pipeline of outstanding request addresses.
  int cyc = 0;
  int lat = 4;
  int mq_addr[$];
  int mq_due[$];
  bit inject_idle = 1'b0;

  int obs_busy, obs_tags, obs_reads, obs_first_req, obs_tag_addr;
  bit obs_first_seen;

  typedef struct {
    logic [15:0] addr;
    int          lat;
    logic [15:0] first_req;
    logic [15:0] tag_addr;
    int          busy;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int word_off(input int k);
    return ((m_w0 + k) % NW) * 2;
  endfunction

  task automatic clear_obs();
    obs_busy = 0; obs_tags = 0; obs_reads = 0;
    obs_first_req = -1; obs_tag_addr = -1; obs_first_seen = 1'b0;
  endtask

  task automatic drive_mem();
    memory_data_valid = 1'b0;
    memory_data = '0;
    if (mq_due.size() > 0 && mq_due[0] == cyc) begin
      memory_data_valid = 1'b1;
      memory_data = 16'(mq_addr[0]) ^ 16'hA5A5;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else if (inject_idle && !m_busy && mq_due.size() == 0 && $urandom_range(0, 2) == 0) begin
      memory_data_valid = 1'b1;
      memory_data = 16'($urandom);
    end
  endtask

  // One clock: check at negedge, advance model, then drive next inputs 1ns after posedge.
  task automatic step();
    bit exp_read, exp_wda, exp_tag;
    @(negedge clk);
    exp_read = m_busy && (m_issued < NW);
    exp_wda  = m_busy && memory_data_valid;
    exp_tag  = exp_wda && (m_recv == NW - 1);
    chk("busy", fsm_busy, m_busy);
    chk("read", memory_read, exp_read);
    if (exp_read) chk("req_addr", memory_address, m_base + word_off(m_issued));
    chk("wr_data", write_data_array, exp_wda);
    chk("wr_tag", write_tag_array, exp_tag);
    if (exp_wda) begin
      chk("wr_addr", cache_word_addr, m_base + word_off(m_recv));
      chk("wr_data_match", memory_data ^ 16'hA5A5, cache_word_addr);
    end
    if (fsm_busy) obs_busy++;
    if (memory_read) begin
      if (!obs_first_seen) obs_first_req = memory_address;
      obs_first_seen = 1'b1;
      obs_reads++;
      mq_addr.push_back(memory_address);
      mq_due.push_back(cyc + lat);
    end
    if (write_tag_array) begin
      obs_tags++;
      obs_tag_addr = cache_word_addr;
    end
    if (m_busy) begin
      if (exp_read) m_issued++;
      if (memory_data_valid) begin
        if (m_recv == NW - 1) m_busy = 1'b0;
        else m_recv++;
      end
    end else if (miss_detected) begin
      m_busy   = 1'b1;
      m_base   = miss_address & ~(2 * NW - 1) & 16'hFFFF;
      m_w0     = CWF ? (miss_address >> 1) % NW : 0;
      m_issued = 0;
      m_recv   = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    drive_mem();
  endtask

  task automatic run_fill(input logic [15:0] a, input int l, input bit hold);
    clear_obs();
    lat = l;
    miss_address = a;
    miss_detected = 1'b1;
    step();
    if (!hold) miss_detected = 1'b0;
    for (int i = 0; i < 64 && m_busy; i++) step();
    chk("fill_done", m_busy, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, fsm_busy, 0);
    chk({tag, "_read"}, memory_read, 0);
    chk({tag, "_maddr"}, memory_address, 0);
    chk({tag, "_wda"}, write_data_array, 0);
    chk({tag, "_wtag"}, write_tag_array, 0);
    chk({tag, "_caddr"}, cache_word_addr, 0);
  endtask

  initial begin
    vecs[0] = '{16'h1236, 4, CWF ? 16'h1236 : 16'h1230, CWF ? 16'h1234 : 16'h123E, 12};
    vecs[1] = '{16'h0000, 1, 16'h0000, 16'h000E, 9};
    vecs[2] = '{16'hFFFE, 2, CWF ? 16'hFFFE : 16'hFFF0, CWF ? 16'hFFFC : 16'hFFFE, 10};
    vecs[3] = '{16'hABC3, 7, CWF ? 16'hABC2 : 16'hABC0, CWF ? 16'hABC0 : 16'hABCE, 15};
    vecs[4] = '{16'h5A5A, 8, CWF ? 16'h5A5A : 16'h5A50, CWF ? 16'h5A58 : 16'h5A5E, 16};

    #2;
    check_outputs_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_fill(vecs[v].addr, vecs[v].lat, 1'b0);
      chk("busy_cycles", obs_busy, vecs[v].busy);
      chk("first_req", obs_first_req, vecs[v].first_req);
      chk("tag_addr", obs_tag_addr, vecs[v].tag_addr);
      chk("tag_count", obs_tags, 1);
      chk("read_count", obs_reads, NW);
      step();
    end

    // Miss held through the fill and its completion: one idle cycle, then a fresh fill.
    run_fill(16'h2468, 4, 1'b1);
    chk("hold_reads", obs_reads, NW);
    chk("hold_tags", obs_tags, 1);
    chk("hold_idle_gap", fsm_busy, 0);
    step();
    chk("hold_rearm", fsm_busy, 1);
    miss_detected = 1'b0;
    for (int i = 0; i < 64 && m_busy; i++) step();
    chk("rearm_done", m_busy, 1'b0);

    // Reset after the third returned word of a fill.
    clear_obs();
    lat = 4;
    miss_address = 16'hFFF0;
    miss_detected = 1'b1;
    step();
    miss_detected = 1'b0;
    for (int i = 0; i < 64 && m_recv < 3; i++) step();
    chk("pre_reset_recv", m_recv, 3);
    #2 rst = 1'b0;
    memory_data_valid = 1'b1;
    miss_detected = 1'b1;
    #1;
    check_outputs_zero("abort");
    chk("abort_no_tag", obs_tags, 0);
    m_busy = 1'b0; m_issued = 0; m_recv = 0;
    mq_addr.delete();
    mq_due.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    memory_data_valid = 1'b0;
    miss_detected = 1'b0;
    #1;
    chk("post_reset_busy", fsm_busy, 0);

    // Stray memory valids while idle must not write.
    clear_obs();
    inject_idle = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("idle_inject_tags", obs_tags, 0);
    chk("idle_inject_busy", obs_busy, 0);

    // Random fills with random latency, miss noise during fill, idle valid noise.
    for (int f = 0; f < 24; f++) begin
      miss_detected = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      clear_obs();
      lat = $urandom_range(1, 8);
      miss_address = 16'($urandom);
      miss_detected = 1'b1;
      step();
      for (int i = 0; i < 64 && m_busy; i++) begin
        miss_detected = 1'($urandom_range(0, 1));
        miss_address = 16'($urandom);
        step();
      end
      chk("rand_done", m_busy, 1'b0);
      chk("rand_tags", obs_tags, 1);
      chk("rand_reads", obs_reads, NW);
      chk("rand_busy", obs_busy, NW + lat);
    end
    miss_detected = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
